// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - shared CSI-2 TX scheduler types, data-type codes and helpers
// Provides: DT_* data-type codes, frame-number width, VC index width,
//           scheduler state enum, frame-number increment helper.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam int FNUM_W = 16;
    localparam int VC_W   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_HDR,
        S_PAYLOAD,
        S_GAP
    } state_t;

    // Frame numbers skip zero on wrap: 0 means "no frame number" downstream.
    function automatic logic [FNUM_W-1:0] fnum_next(input logic [FNUM_W-1:0] cur);
        return (cur == '1) ? FNUM_W'(1) : cur + FNUM_W'(1);
    endfunction

endpackage

// File: rtl/csi2_rr_arbiter.sv
// rtl/csi2_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req_i   request vector
//        ptr_i   first index eligible this round
//        grant_o one-hot grant, idx_o grant index, any_o any request present
module csi2_rr_arbiter
    import csi2_pkg::*;
#(
    parameter int NUM_VC = 4
) (
    input  logic [NUM_VC-1:0] req_i,
    input  logic [VC_W-1:0]   ptr_i,
    output logic [NUM_VC-1:0] grant_o,
    output logic [VC_W-1:0]   idx_o,
    output logic              any_o
);

    localparam int CW = VC_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    // Scan NUM_VC positions starting at ptr_i, wrapping modulo NUM_VC.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand = {1'b0, ptr_i} + CW'(i);
            if (cand >= CW'(NUM_VC)) begin
                cand = cand - CW'(NUM_VC);
            end
            if (!found && req_i[cand[VC_W-1:0]]) begin
                found                     = 1'b1;
                idx_o                     = cand[VC_W-1:0];
                grant_o[cand[VC_W-1:0]]   = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/csi2_tx_vc_scheduler.sv
// rtl/csi2_tx_vc_scheduler.sv - per-packet round-robin CSI-2 TX virtual-channel scheduler
// Ports: req_valid/req_ready/req_dt/req_wc  per-VC packet requests
//        pay_valid/pay_ready/pay_data        per-VC payload byte streams
//        hdr_valid/hdr_ready/hdr_vc/dt/wc    header handshake to packet builder
//        out_valid/out_ready/out_data/last   payload byte stream to packet builder
//        busy, proto_err (pulse), err_vc (held)
module csi2_tx_vc_scheduler
    import csi2_pkg::*;
#(
    parameter int NUM_VC     = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_VC-1:0]      req_valid,
    output logic [NUM_VC-1:0]      req_ready,
    input  logic [6*NUM_VC-1:0]    req_dt,
    input  logic [16*NUM_VC-1:0]   req_wc,
    input  logic [NUM_VC-1:0]      pay_valid,
    output logic [NUM_VC-1:0]      pay_ready,
    input  logic [8*NUM_VC-1:0]    pay_data,
    output logic                   hdr_valid,
    input  logic                   hdr_ready,
    output logic [1:0]             hdr_vc,
    output logic [5:0]             hdr_dt,
    output logic [15:0]            hdr_wc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   proto_err,
    output logic [1:0]             err_vc
);

    localparam int     GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // A zero-length gap skips the GAP state entirely.
    localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t                          state_q, state_d;
    logic [VC_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]                 vc_q, vc_d;
    logic [5:0]                      dt_q, dt_d;
    logic [15:0]                     wc_q, wc_d;
    logic [15:0]                     rem_q, rem_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [NUM_VC-1:0]               frame_active_q, frame_active_d;
    logic [NUM_VC-1:0][FNUM_W-1:0]   frame_num_q;
    logic                            proto_err_q, proto_err_d;
    logic [VC_W-1:0]                 err_vc_q, err_vc_d;
    logic                            fnum_inc;

    logic [NUM_VC-1:0]               win_grant;
    logic [VC_W-1:0]                 win_idx;
    logic                            win_any;
    logic [5:0]                      win_dt;
    logic [15:0]                     win_wc;
    logic [FNUM_W-1:0]               win_fnum;
    logic                            win_legal;

    csi2_rr_arbiter #(.NUM_VC(NUM_VC)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    assign win_dt   = req_dt[int'(win_idx)*6 +: 6];
    assign win_wc   = req_wc[int'(win_idx)*16 +: 16];
    assign win_fnum = frame_num_q[win_idx];

    always_comb begin
        win_legal = 1'b1;
        if (win_dt == DT_FS) begin
            win_legal = !frame_active_q[win_idx];
        end else if ((win_dt >= DT_LONG_MIN) || (win_dt inside {DT_FE, DT_LS, DT_LE})) begin
            win_legal = frame_active_q[win_idx];
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        vc_d           = vc_q;
        dt_d           = dt_q;
        wc_d           = wc_q;
        rem_d          = rem_q;
        gap_d          = gap_q;
        frame_active_d = frame_active_q;
        err_vc_d       = err_vc_q;
        proto_err_d    = 1'b0;
        fnum_inc       = 1'b0;
        req_ready      = '0;
        pay_ready      = '0;
        hdr_valid      = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_any) begin
                    req_ready = win_grant;
                    vc_d      = win_idx;
                    dt_d      = win_dt;
                    wc_d      = win_wc;
                    rr_ptr_d  = (win_idx == VC_W'(NUM_VC - 1)) ? '0 : win_idx + 1'b1;
                    if (win_legal) begin
                        state_d = S_HDR;
                        if (win_dt == DT_FS) begin
                            fnum_inc                = 1'b1;
                            wc_d                    = fnum_next(win_fnum);
                            frame_active_d[win_idx] = 1'b1;
                        end else if (win_dt == DT_FE) begin
                            wc_d                    = win_fnum;
                            frame_active_d[win_idx] = 1'b0;
                        end
                    end else begin
                        // Dropped request: consumed, no header, frame state untouched.
                        proto_err_d = 1'b1;
                        err_vc_d    = win_idx;
                        gap_d       = '0;
                        state_d     = S_AFTER;
                    end
                end else begin
                    // Requester withdrew between IDLE and ARB.
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                hdr_valid = 1'b1;
                if (hdr_ready) begin
                    gap_d = '0;
                    if ((dt_q >= DT_LONG_MIN) && (wc_q != '0)) begin
                        rem_d   = wc_q;
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_AFTER;
                    end
                end
            end
            S_PAYLOAD: begin
                out_valid         = pay_valid[vc_q];
                out_data          = pay_data[int'(vc_q)*8 +: 8];
                pay_ready[vc_q]   = out_ready;
                out_last          = (rem_q == 16'd1);
                if (out_valid && out_ready) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        gap_d   = '0;
                        state_d = S_AFTER;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            vc_q           <= '0;
            dt_q           <= '0;
            wc_q           <= '0;
            rem_q          <= '0;
            gap_q          <= '0;
            frame_active_q <= '0;
            frame_num_q    <= '0;
            proto_err_q    <= 1'b0;
            err_vc_q       <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            vc_q           <= vc_d;
            dt_q           <= dt_d;
            wc_q           <= wc_d;
            rem_q          <= rem_d;
            gap_q          <= gap_d;
            frame_active_q <= frame_active_d;
            proto_err_q    <= proto_err_d;
            err_vc_q       <= err_vc_d;
            if (fnum_inc) begin
                frame_num_q[win_idx] <= fnum_next(win_fnum);
            end
        end
    end

    assign hdr_vc    = vc_q;
    assign hdr_dt    = dt_q;
    assign hdr_wc    = wc_q;
    assign busy      = (state_q != S_IDLE);
    assign proto_err = proto_err_q;
    assign err_vc    = err_vc_q;

endmodule

// File: tb/tb_csi2_tx_vc_scheduler.sv
// tb/tb_csi2_tx_vc_scheduler.sv - scoreboard bench for csi2_tx_vc_scheduler
module tb_csi2_tx_vc_scheduler;

    localparam int NV  = 4;
    localparam int GAP = 2;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } hdr_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NV-1:0]   req_valid;
    logic [NV-1:0]   req_ready;
    logic [6*NV-1:0] req_dt;
    logic [16*NV-1:0] req_wc;
    logic [NV-1:0]   pay_valid;
    logic [NV-1:0]   pay_ready;
    logic [8*NV-1:0] pay_data;
    logic            hdr_valid, hdr_ready;
    logic [1:0]      hdr_vc;
    logic [5:0]      hdr_dt;
    logic [15:0]     hdr_wc;
    logic            out_valid, out_ready, out_last;
    logic [7:0]      out_data;
    logic            busy, proto_err;
    logic [1:0]      err_vc;

    int vectors = 0;
    int miscompares = 0;
    int out_mode = 0;   // 0: out_ready high, 1: toggling, 2: held low

    hdr_t        exp_hdr[$];
    logic [8:0]  exp_byte[$];
    logic [1:0]  exp_err[$];
    logic [7:0]  pay_q[NV][$];
    int          grant_order[$];

    always #5 clk = ~clk;

    csi2_tx_vc_scheduler #(.NUM_VC(NV), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dt(req_dt), .req_wc(req_wc),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt),
        .hdr_wc(hdr_wc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .proto_err(proto_err), .err_vc(err_vc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    initial begin
        hdr_t       eh;
        logic [8:0] eb;
        forever begin
            @(negedge clk); #3;
            if (reset_n) begin
                if (hdr_valid && hdr_ready) begin
                    if (exp_hdr.size() == 0) fail_msg("hdr_unexpected", $sformatf("got vc=%0d dt=%0h wc=%0h", hdr_vc, hdr_dt, hdr_wc));
                    else begin
                        eh = exp_hdr.pop_front();
                        check("hdr", {40'd0, hdr_vc, hdr_dt, hdr_wc}, {40'd0, eh});
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_byte.size() == 0) fail_msg("byte_unexpected", $sformatf("got %0h last=%0b", out_data, out_last));
                    else begin
                        eb = exp_byte.pop_front();
                        check("byte", {55'd0, out_data, out_last}, {55'd0, eb});
                    end
                end
                if (proto_err) begin
                    if (exp_err.size() == 0) fail_msg("err_unexpected", $sformatf("got err_vc=%0d", err_vc));
                    else check("err_vc", {62'd0, err_vc}, {62'd0, exp_err.pop_front()});
                end
            end
        end
    end

    // Payload sources: each VC presents the head of its byte queue.
    initial begin
        logic [NV-1:0] hs;
        pay_valid = '0;
        pay_data  = '0;
        forever begin
            @(negedge clk); #3;
            hs = pay_valid & pay_ready;
            @(posedge clk); #1;
            for (int v = 0; v < NV; v++) begin
                if (hs[v] && pay_q[v].size() > 0) void'(pay_q[v].pop_front());
                pay_valid[v] = (pay_q[v].size() > 0);
                pay_data[v*8 +: 8] = (pay_q[v].size() > 0) ? pay_q[v][0] : 8'h00;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (out_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    logic [5:0]  cfg_dt[NV];
    logic [15:0] cfg_wc[NV];

    task automatic issue(input logic [NV-1:0] mask);
        logic [NV-1:0] pend, got;
        int c;
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) begin
                req_dt[v*6 +: 6]   = cfg_dt[v];
                req_wc[v*16 +: 16] = cfg_wc[v];
                req_valid[v]       = 1'b1;
            end
        end
        pend = mask;
        c = 0;
        while (pend != '0 && c < 100) begin
            #3;
            got = req_ready & pend;
            @(posedge clk); #1;
            for (int v = 0; v < NV; v++) begin
                if (got[v]) begin
                    req_valid[v] = 1'b0;
                    pend[v] = 1'b0;
                    grant_order.push_back(v);
                end
            end
            c++;
        end
        if (pend != '0) begin
            req_valid = req_valid & ~pend;
            fail_msg("grant_timeout", $sformatf("pending mask %0b", pend));
        end
    endtask

    task automatic send(input int vc, input logic [5:0] dt, input logic [15:0] wc,
                        input logic [15:0] exp_wc, input bit legal);
        if (legal) exp_hdr.push_back('{vc: 2'(vc), dt: dt, wc: exp_wc});
        else exp_err.push_back(2'(vc));
        cfg_dt[vc] = dt;
        cfg_wc[vc] = wc;
        issue(NV'(1) << vc);
    endtask

    task automatic wait_idle();
        int c = 0;
        bit done = 0;
        while (!done && c < 500) begin
            @(negedge clk); #3;
            c++;
            done = !busy && exp_hdr.size() == 0 && exp_byte.size() == 0 && exp_err.size() == 0;
        end
        if (!done) fail_msg("idle_timeout", $sformatf("busy=%0b hdr_q=%0d byte_q=%0d", busy, exp_hdr.size(), exp_byte.size()));
    endtask

    // Counts busy cycles after the next header handshake.
    task automatic measure_gap(output int n);
        int c = 0;
        bit seen = 0;
        n = 0;
        while (!seen && c < 100) begin
            @(negedge clk); #3;
            seen = hdr_valid && hdr_ready;
            c++;
        end
        c = 0;
        do begin
            @(negedge clk); #3;
            if (busy) n++;
            c++;
        end while (busy && c < 100);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #3;
        check("reset_outputs",
              {17'd0, req_ready, pay_ready, hdr_valid, hdr_vc, hdr_dt, hdr_wc,
               out_valid, out_data, out_last, busy, proto_err, err_vc}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n, hv, pe, nb;
        bit bad;
        reset_n   = 1'b0;
        req_valid = '0;
        req_dt    = '0;
        req_wc    = '0;
        hdr_ready = 1'b1;

        // Single-VC frame sequence.
        do_reset();
        send(0, 6'h00, 16'h1234, 16'h0001, 1);
        measure_gap(n);
        check("gap_after_fs", 64'(n), 64'(GAP));
        send(0, 6'h02, 16'h0007, 16'h0007, 1);
        measure_gap(n);
        check("gap_after_ls", 64'(n), 64'(GAP));
        pay_q[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_byte.push_back({8'h11, 1'b0});
        exp_byte.push_back({8'h22, 1'b0});
        exp_byte.push_back({8'h33, 1'b0});
        exp_byte.push_back({8'h44, 1'b1});
        send(0, 6'h2A, 16'd4, 16'd4, 1);
        send(0, 6'h03, 16'h0005, 16'h0005, 1);
        send(0, 6'h01, 16'hABCD, 16'h0001, 1);
        wait_idle();

        // All four VCs request FS together from reset.
        do_reset();
        grant_order.delete();
        for (int v = 0; v < NV; v++) begin
            cfg_dt[v] = 6'h00;
            cfg_wc[v] = 16'h0000;
            exp_hdr.push_back('{vc: 2'(v), dt: 6'h00, wc: 16'h0001});
        end
        issue(4'b1111);
        check("grant_count", 64'(grant_order.size()), 64'd4);
        for (int k = 0; k < grant_order.size() && k < 4; k++)
            check($sformatf("grant_order_%0d", k), 64'(grant_order[k]), 64'(k));
        wait_idle();
        // Pointer is back at 0, so VC0 wins over VC1.
        grant_order.delete();
        cfg_dt[0] = 6'h01; cfg_wc[0] = 16'h0;
        cfg_dt[1] = 6'h01; cfg_wc[1] = 16'h0;
        exp_hdr.push_back('{vc: 2'd0, dt: 6'h01, wc: 16'h0001});
        exp_hdr.push_back('{vc: 2'd1, dt: 6'h01, wc: 16'h0001});
        issue(4'b0011);
        check("rr_wrap_first", (grant_order.size() > 0) ? 64'(grant_order[0]) : 64'hFF, 64'd0);
        wait_idle();

        // Illegal LS on VC1 with no open frame.
        send(1, 6'h02, 16'h0003, 16'h0000, 0);
        hv = 0; pe = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            hv += int'(hdr_valid);
            pe += int'(proto_err);
        end
        check("illegal_no_hdr", 64'(hv), 64'd0);
        check("illegal_err_pulse", 64'(pe), 64'd1);
        check("err_vc_held", 64'(err_vc), 64'd1);
        send(1, 6'h00, 16'h0000, 16'h0002, 1);
        wait_idle();

        // Long packet on VC2 with stalled header and toggling out_ready.
        hdr_ready = 1'b0;
        pay_q[2] = '{8'hA1, 8'hB2, 8'hC3};
        exp_byte.push_back({8'hA1, 1'b0});
        exp_byte.push_back({8'hB2, 1'b0});
        exp_byte.push_back({8'hC3, 1'b1});
        send(2, 6'h30, 16'd3, 16'd3, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            check("hdr_stall", {39'd0, hdr_valid, hdr_vc, hdr_dt, hdr_wc}, {39'd0, 1'b1, 2'd2, 6'h30, 16'd3});
        end
        @(posedge clk); #1;
        hdr_ready = 1'b1;
        out_mode = 1;
        bad = 0; nb = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clk); #3;
            if ((pay_ready & 4'b1011) != 0) bad = 1;
            if (out_valid && out_ready) nb++;
        end
        check("other_pay_ready", 64'(bad), 64'd0);
        check("long_byte_count", 64'(nb), 64'd3);
        out_mode = 0;
        wait_idle();

        // Frame-number wrap on VC2.
        send(2, 6'h01, 16'h0000, 16'h0001, 1);
        wait_idle();
        @(negedge clk);
        dut.frame_num_q[2] = 16'hFFFF;
        send(2, 6'h00, 16'h0000, 16'h0001, 1);
        send(2, 6'h01, 16'h0000, 16'h0001, 1);
        wait_idle();

        // Reset while VC3 is in PAYLOAD.
        out_mode = 2;
        pay_q[3] = '{8'h51, 8'h52, 8'h53, 8'h54};
        send(3, 6'h2B, 16'd4, 16'd4, 1);
        @(negedge clk); #3;
        @(negedge clk); #3;
        check("pre_reset_payload", {62'd0, out_valid, busy}, {62'd0, 2'b11});
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {17'd0, req_ready, pay_ready, hdr_valid, hdr_vc, hdr_dt, hdr_wc,
               out_valid, out_data, out_last, busy, proto_err, err_vc}, 64'd0);
        pay_q[3].delete();
        out_mode = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #3;
        check("idle_after_reset", 64'(busy), 64'd0);
        send(3, 6'h00, 16'h0000, 16'h0001, 1);
        send(3, 6'h01, 16'h0000, 16'h0001, 1);
        wait_idle();

        check("hdr_queue_drained", 64'(exp_hdr.size()), 64'd0);
        check("byte_queue_drained", 64'(exp_byte.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
